// File: rtl/alarm_clock_core.sv
// ---------------------------------------------------------------------------
// alarm_clock_core
//
// Processor-free 24-hour clock with NUM_ALARMS programmable alarms, a
// four-key debounced push-button UI, six 7-segment digits and a 10-LED bank.
//
// Ports:
//   clk_clk                 system clock
//   reset_reset_n           synchronous, active-low reset
//   set_mode_button_export  raw key, 0 = pressed; cycles RUN/SET_TIME/SET_ALARMk
//   inc_hour_button_export  raw key, 0 = pressed; increments shadow hour
//   inc_min_button_export   raw key, 0 = pressed; increments shadow minute
//   confirm_button_export   raw key, 0 = pressed; commits shadow / dismisses ring
//   hour_1/2_export         hour tens/units, segments gfedcba, active-low
//   min_1/2_export          minute tens/units
//   sec_1/2_export          second tens/units (or "--" / "A"+slot in set modes)
//   leds_export             alarm enables + mode bits, or ring flash
// ---------------------------------------------------------------------------
module alarm_clock_core #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int NUM_ALARMS      = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RING_SEC        = 60
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       set_mode_button_export,
  input  logic       inc_hour_button_export,
  input  logic       inc_min_button_export,
  input  logic       confirm_button_export,
  output logic [6:0] hour_1_export,
  output logic [6:0] hour_2_export,
  output logic [6:0] min_1_export,
  output logic [6:0] min_2_export,
  output logic [6:0] sec_1_export,
  output logic [6:0] sec_2_export,
  output logic [9:0] leds_export
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_A    = 7'b0001000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_TIME,
    ST_SET_ALARM
  } ui_state_t;

  // Key bit order: 3 = confirm, 2 = set_mode, 1 = inc_hour, 0 = inc_min
  logic [3:0]    raw_keys;
  logic [3:0]    sync1, sync2, stable, pulse;
  logic [DW-1:0] db_cnt [4];

  logic            confirm_p, set_p, inc_h_p, inc_m_p;
  logic            dismiss, ui_confirm;

  ui_state_t       state;
  logic [SW-1:0]   alarm_sel;
  logic [PW-1:0]   presc;
  logic [7:0]      hour_bcd, min_bcd, sec_bcd;
  logic [7:0]      sh_hour, sh_min;
  logic [7:0]      alarm_hour [NUM_ALARMS];
  logic [7:0]      alarm_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alarm_en;
  logic            ringing, ring_on;
  logic [RW-1:0]   ring_cnt;

  logic            tick, alarm_hit, match_now;
  logic [7:0]      nxt_hour, nxt_min, nxt_sec;
  logic [7:0]      disp_hour, disp_min;
  logic [6:0]      disp_s1, disp_s2;
  logic [9:0]      leds_next;

  // Increment a two-digit BCD value, wrapping to 00 after top
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign raw_keys = {confirm_button_export, set_mode_button_export,
                     inc_hour_button_export, inc_min_button_export};

  // Synchronise each key, then accept a new level only once it has been
  // seen for DEBOUNCE_CYCLES samples in a row. The counter runs only while
  // the synchronised level differs from the accepted one, so any bounce back
  // restarts it. A pulse is emitted on an accepted release->press change.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1  <= 4'hF;
      sync2  <= 4'hF;
      stable <= 4'hF;
      pulse  <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          stable[i] <= sync2[i];
          pulse[i]  <= stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the highest-priority pulse survives a same-cycle collision.
  // A confirm while ringing is used up by the dismiss.
  assign confirm_p  = pulse[3];
  assign set_p      = pulse[2] & ~pulse[3];
  assign inc_h_p    = pulse[1] & ~(|pulse[3:2]);
  assign inc_m_p    = pulse[0] & ~(|pulse[3:1]);
  assign dismiss    = confirm_p & ringing;
  assign ui_confirm = confirm_p & ~ringing;

  assign tick = (state != ST_SET_TIME) && (presc == PW'(CLK_FREQ_HZ - 1));

  // Time after the pending tick, and whether it lands on an enabled alarm
  always_comb begin
    nxt_sec  = bcd_inc(sec_bcd, 8'h59);
    nxt_min  = min_bcd;
    nxt_hour = hour_bcd;
    if (sec_bcd == 8'h59) begin
      nxt_min = bcd_inc(min_bcd, 8'h59);
      if (min_bcd == 8'h59) nxt_hour = bcd_inc(hour_bcd, 8'h23);
    end
    alarm_hit = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (alarm_en[k] && alarm_hour[k] == nxt_hour && alarm_min[k] == nxt_min)
        alarm_hit = 1'b1;
    end
  end

  assign match_now = tick && (nxt_sec == 8'h00) && alarm_hit;

  // What the digits and LEDs should show for the current state
  always_comb begin
    disp_hour = hour_bcd;
    disp_min  = min_bcd;
    disp_s1   = seg7(sec_bcd[7:4]);
    disp_s2   = seg7(sec_bcd[3:0]);
    leds_next = {2'b00, 8'(alarm_en)};
    case (state)
      ST_SET_TIME: begin
        disp_hour = sh_hour;
        disp_min  = sh_min;
        disp_s1   = SEG_DASH;
        disp_s2   = SEG_DASH;
        leds_next[9:8] = 2'b01;
      end
      ST_SET_ALARM: begin
        disp_hour = sh_hour;
        disp_min  = sh_min;
        disp_s1   = SEG_A;
        disp_s2   = seg7(4'(alarm_sel));
        leds_next[9:8] = 2'b10;
      end
      default: ;
    endcase
    if (ringing) leds_next = ring_on ? 10'h3FF : 10'h000;
  end

  // Timekeeping, ring control, UI state machine and registered outputs.
  // Outputs are loaded from the current registers, so they trail any
  // state or time change by one cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state     <= ST_RUN;
      alarm_sel <= '0;
      presc     <= '0;
      hour_bcd  <= 8'h00;
      min_bcd   <= 8'h00;
      sec_bcd   <= 8'h00;
      sh_hour   <= 8'h00;
      sh_min    <= 8'h00;
      alarm_en  <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alarm_hour[k] <= 8'h00;
        alarm_min[k]  <= 8'h00;
      end
      ringing  <= 1'b0;
      ring_on  <= 1'b0;
      ring_cnt <= '0;
      hour_1_export <= SEG_ZERO;
      hour_2_export <= SEG_ZERO;
      min_1_export  <= SEG_ZERO;
      min_2_export  <= SEG_ZERO;
      sec_1_export  <= SEG_ZERO;
      sec_2_export  <= SEG_ZERO;
      leds_export   <= 10'h000;
    end else begin
      if (state != ST_SET_TIME) begin
        if (tick) begin
          presc    <= '0;
          sec_bcd  <= nxt_sec;
          min_bcd  <= nxt_min;
          hour_bcd <= nxt_hour;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      // A fresh match (re)starts the ring with the LEDs lit, so it takes
      // precedence over a dismiss landing in the same cycle.
      if (match_now) begin
        ringing  <= 1'b1;
        ring_on  <= 1'b1;
        ring_cnt <= RW'(RING_SEC);
      end else if (dismiss) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
      end else if (tick && ringing) begin
        ring_on <= ~ring_on;
        if (ring_cnt <= RW'(1)) begin
          ringing  <= 1'b0;
          ring_cnt <= '0;
        end else begin
          ring_cnt <= ring_cnt - 1'b1;
        end
      end

      case (state)
        ST_RUN: begin
          if (set_p) begin
            state   <= ST_SET_TIME;
            sh_hour <= hour_bcd;
            sh_min  <= min_bcd;
          end
        end
        ST_SET_TIME: begin
          if (ui_confirm) begin
            hour_bcd <= sh_hour;
            min_bcd  <= sh_min;
            sec_bcd  <= 8'h00;
            presc    <= '0;
            state    <= ST_RUN;
          end else if (set_p) begin
            state     <= ST_SET_ALARM;
            alarm_sel <= '0;
            sh_hour   <= alarm_hour[0];
            sh_min    <= alarm_min[0];
          end else if (inc_h_p) begin
            sh_hour <= bcd_inc(sh_hour, 8'h23);
          end else if (inc_m_p) begin
            sh_min <= bcd_inc(sh_min, 8'h59);
          end
        end
        ST_SET_ALARM: begin
          if (ui_confirm) begin
            // Re-confirming an unchanged enabled slot toggles it off
            if (alarm_en[alarm_sel] && sh_hour == alarm_hour[alarm_sel]
                && sh_min == alarm_min[alarm_sel]) begin
              alarm_en[alarm_sel] <= 1'b0;
            end else begin
              alarm_hour[alarm_sel] <= sh_hour;
              alarm_min[alarm_sel]  <= sh_min;
              alarm_en[alarm_sel]   <= 1'b1;
            end
            state <= ST_RUN;
          end else if (set_p) begin
            if (alarm_sel == SW'(NUM_ALARMS - 1)) begin
              state <= ST_RUN;
            end else begin
              alarm_sel <= alarm_sel + 1'b1;
              sh_hour   <= alarm_hour[alarm_sel + 1'b1];
              sh_min    <= alarm_min[alarm_sel + 1'b1];
            end
          end else if (inc_h_p) begin
            sh_hour <= bcd_inc(sh_hour, 8'h23);
          end else if (inc_m_p) begin
            sh_min <= bcd_inc(sh_min, 8'h59);
          end
        end
        default: state <= ST_RUN;
      endcase

      hour_1_export <= seg7(disp_hour[7:4]);
      hour_2_export <= seg7(disp_hour[3:0]);
      min_1_export  <= seg7(disp_min[7:4]);
      min_2_export  <= seg7(disp_min[3:0]);
      sec_1_export  <= disp_s1;
      sec_2_export  <= disp_s2;
      leds_export   <= leds_next;
    end
  end

endmodule
